// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// UART transmit serializer. A parallel word accepted on DATA_VALID (while
// BUSY is low) is shifted out on TX_OUT as an asynchronous frame:
//   start (0), DATA_WIDTH data bits LSB first, [parity], stop (1).
// One frame bit is sent per rising edge of CLK (CLK is the TX baud clock).
//
// Build option:
//   UART_TX_PARITY_EN - when defined, adds the PAR_TYP port and a parity
//                       bit between the last data bit and the stop bit.
//                       When undefined, frames carry no parity bit.
//
// Parameters:
//   DATA_WIDTH  width of the parallel word (>= 2), default 8
//
// Ports:
//   CLK         in   TX bit clock, rising edge active
//   RST         in   synchronous reset, active low
//   P_DATA      in   word to transmit, sampled only on acceptance
//   DATA_VALID  in   send request, honoured only while BUSY = 0
//   PAR_TYP     in   0 = even, 1 = odd parity (UART_TX_PARITY_EN only)
//   TX_OUT      out  serial line, idle high, driven from a flop
//   BUSY        out  high from acceptance through the stop-bit cycle
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
`ifdef UART_TX_PARITY_EN
    input  logic                  PAR_TYP,
`endif
    output logic                  TX_OUT,
    output logic                  BUSY
);

    // One spare bit so the counter can never wrap inside a frame.
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  tx_q;
    logic                  busy_q;
`ifdef UART_TX_PARITY_EN
    logic                  par_typ_q;
    logic                  par_bit_q;
    logic                  par_bit_d;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    assign par_bit_d = (^P_DATA) ^ PAR_TYP;
`endif

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            // Reset aborts any frame in flight; no stop bit is emitted.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_typ_q <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (DATA_VALID) begin
                        // Acceptance: capture everything the frame needs so
                        // later input changes cannot disturb it.
                        shift_q   <= P_DATA;
`ifdef UART_TX_PARITY_EN
                        par_typ_q <= PAR_TYP;
                        par_bit_q <= par_bit_d;
`endif
                        cnt_q     <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end
                end

                ST_START: begin
                    // Line drops to bit 0; shift so shift_q[0] always holds
                    // the next bit to send.
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    cnt_q   <= '0;
                    state_q <= ST_DATA;
                end

                ST_DATA: begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
                        tx_q    <= par_bit_q;
                        state_q <= ST_PARITY;
`else
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
`endif
                    end else begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        cnt_q   <= cnt_d;
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_STOP;
                end
`endif

                ST_STOP: begin
                    // Stop bit ends here; the line stays high and at least
                    // one idle cycle follows before any new start bit.
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed bench for uart_tx_serializer (DATA_WIDTH = 8). Works with or
// without UART_TX_PARITY_EN; the expected frame length and parity bit
// follow the same macro. Expected data words and parity bits are written
// out by hand for each step.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_LEN = DW + 3;
`else
    localparam int FRAME_LEN = DW + 2;
`endif

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
`ifdef UART_TX_PARITY_EN
    logic          PAR_TYP;
`endif
    logic          TX_OUT;
    logic          BUSY;

    int checks;
    int fails;

    uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
`ifdef UART_TX_PARITY_EN
        .PAR_TYP    (PAR_TYP),
`endif
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Safety net: the sequence below is finite, this only catches a hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected end before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " tx"}, TX_OUT, 1'b1);
        chk({tag, " busy"}, BUSY, 1'b0);
    endtask

    // Sends one word and checks every line bit plus BUSY, then the idle
    // cycle after the stop bit.
    //   pulse_mask : DATA_VALID level driven after frame sample k
    //   hold       : keep DATA_VALID high through and after the frame
    //   corrupt    : change P_DATA/PAR_TYP right after acceptance
    task automatic send_frame(input string tag, input logic [DW-1:0] d,
                              input logic ptyp, input logic exp_par,
                              input logic [15:0] pulse_mask,
                              input bit hold, input bit corrupt);
        logic exp_bits [0:FRAME_LEN-1];
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) exp_bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        exp_bits[DW + 1] = exp_par;
`endif
        exp_bits[FRAME_LEN - 1] = 1'b1;

        P_DATA = d;
`ifdef UART_TX_PARITY_EN
        PAR_TYP = ptyp;
`endif
        DATA_VALID = 1'b1;
        tick();
        if (!hold) DATA_VALID = 1'b0;
        if (corrupt) begin
            P_DATA = ~d;
`ifdef UART_TX_PARITY_EN
            PAR_TYP = ~ptyp;
`endif
        end
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (k > 0) tick();
            chk($sformatf("%s bit%0d tx", tag, k), TX_OUT, exp_bits[k]);
            chk($sformatf("%s bit%0d busy", tag, k), BUSY, 1'b1);
            if (!hold) DATA_VALID = pulse_mask[k];
        end
        if (!hold) DATA_VALID = 1'b0;
        tick();
        chk_idle($sformatf("%s after", tag));
        $display("frame %s data=%02h done (%0d checks, %0d failures so far)",
                 tag, d, checks, fails);
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        RST        = 1'b0;
        DATA_VALID = 1'b1;
        P_DATA     = 8'h55;
`ifdef UART_TX_PARITY_EN
        PAR_TYP    = 1'b0;
`endif

        // Reset held for 3 edges with a pending request: nothing starts.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("reset%0d", i));
        end
        DATA_VALID = 1'b0;
        RST        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("post_reset%0d", i));
        end
        $display("reset sequence done (%0d checks, %0d failures so far)", checks, fails);

        // 0xA5 has four ones: even parity 0, odd parity 1.
        send_frame("a5_even", 8'hA5, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        send_frame("a5_odd",  8'hA5, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
        // All zeros, odd parity -> parity 1; inputs change after acceptance.
        send_frame("00_odd_corrupt", 8'h00, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1);
        // 0x5A: line 0,0,1,0,1,1,0,1,0,[0],1.
        send_frame("5a_even", 8'h5A, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

        // Requests pulsed during a busy frame are dropped.
        send_frame("a5_pulses", 8'hA5, 1'b0, 1'b0, 16'h0048, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("no_queue%0d", i));
        end

        // Held request: next start follows exactly one idle cycle.
        send_frame("3c_held1", 8'h3C, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        send_frame("3c_held2", 8'h3C, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        chk_idle("after_held");

        // Reset during data bit 4 of 0xF0 (bits 0..3 = 0, bit 4 = 1).
        P_DATA     = 8'hF0;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        chk("f0 start", TX_OUT, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("f0 data%0d", i), TX_OUT, (i == 4) ? 1'b1 : 1'b0);
        end
        RST        = 1'b0;
        DATA_VALID = 1'b1;
        tick();
        chk_idle("f0 abort");
        RST        = 1'b1;
        DATA_VALID = 1'b0;
        tick();
        chk_idle("f0 released");
        $display("mid-frame reset done (%0d checks, %0d failures so far)", checks, fails);

        // 0x81 has two ones -> even parity 0.
        send_frame("81_even", 8'h81, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit-side serializer: accepts a parallel word on a valid strobe and shifts it onto a single line as a standard asynchronous frame. The frame is start bit, data LSB-first, optional parity, then stop bit. It sits in the TX path of the UART, mirroring the RX deserializer, and runs on the TX baud clock, one bit per CLK cycle. A simple busy/valid handshake connects it to the upstream data source, such as a FIFO read side or the register-file controller.

## Interface
- DATA_WIDTH, 8, width of the parallel data word (≥2).
- CLK  in  1  TX bit clock; every rising edge advances one frame bit.
- RST  in  1  reset, synchronous, active-low.
- P_DATA  in  DATA_WIDTH  parallel word to transmit; sampled only on acceptance.
- DATA_VALID  in  1  request to send P_DATA; honoured only while BUSY=0.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity; sampled on acceptance. Present only with UART_TX_PARITY_EN.
- TX_OUT  out  1  serial line, idle high; driven directly from a flop.
- BUSY  out  1  high from acceptance through the last stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY (compiled in with the macro), STOP.
- Reset (RST=0 at an edge):
  - State goes to IDLE, TX_OUT=1, BUSY=0.
  - Bit counter = 0, shift register = 0, latched parity type = 0.
  - Takes priority over everything, including a frame in progress; the frame is aborted with no stop bit emitted.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - DATA_VALID=1 at an edge is acceptance. The block latches P_DATA into the shift register and PAR_TYP into the latched parity type.
  - At acceptance the parity bit is computed as XOR of P_DATA, XORed with the latched parity type.
  - State goes to START; TX_OUT←0 and BUSY←1 at that same edge.
- START: one cycle with TX_OUT=0. The next edge goes to DATA and drives TX_OUT←bit 0.
- DATA:
  - DATA_WIDTH cycles; TX_OUT carries bit i in cycle i, LSB first.
  - The counter runs 0..DATA_WIDTH-1 and is $clog2(DATA_WIDTH)+1 bits wide, so it never wraps mid-frame.
  - At counter = DATA_WIDTH-1, the next state is PARITY if the macro is defined, otherwise STOP.
  - The counter clears on leaving DATA.
- PARITY: one cycle with TX_OUT = latched parity bit, then STOP.
- STOP:
  - One cycle with TX_OUT=1 and BUSY still 1.
  - The next edge goes to IDLE with BUSY←0 and TX_OUT stays 1.
- Handshake rules:
  - DATA_VALID while BUSY=1 is ignored. Nothing is queued; the source must hold or re-assert it.
  - Changes on P_DATA or PAR_TYP after acceptance have no effect on the frame in flight.
- Simultaneous events: RST=0 together with DATA_VALID=1 → reset wins and nothing is accepted.

## Timing
- Latency: acceptance edge k → TX_OUT low during cycle k..k+1 (start bit), data bits at edges k+1..k+DATA_WIDTH.
- Frame length (BUSY=1 cycles): DATA_WIDTH+2 without parity (10 for default), DATA_WIDTH+3 with parity (11).
- Back-to-back: DATA_VALID held high gives a new acceptance at the first edge where BUSY=0. This leaves exactly one idle-high cycle between the stop bit and the next start bit. The frame period is therefore 11 (no parity) or 12 (parity) cycles.
- All outputs are registered; there are no combinational paths from inputs to TX_OUT or BUSY.

## Configuration
- UART_TX_PARITY_EN defined:
  - PAR_TYP port exists.
  - The PARITY state is inserted between DATA and STOP; frame is DATA_WIDTH+3 bits.
- UART_TX_PARITY_EN undefined:
  - No PAR_TYP port and no parity logic.
  - DATA goes directly to STOP; frame is DATA_WIDTH+2 bits.

## Test plan
- Reset: hold RST=0 for 3 edges with DATA_VALID=1 → TX_OUT=1, BUSY=0 throughout; no frame follows release.
- Parity on, P_DATA=0xA5, PAR_TYP=0 → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop). BUSY high for exactly 11 cycles. Same word with PAR_TYP=1 → parity bit 1.
- Parity on, P_DATA=0x00, PAR_TYP=1 → eight zero data bits, parity 1, stop 1. P_DATA changed to 0xFF one cycle after acceptance → frame unchanged.
- DATA_VALID pulsed at cycles 3 and 6 of a busy frame → both ignored; only one frame on the line. Held high continuously with 0x3C → frames separated by exactly one idle-high cycle.
- Reset mid-frame: RST=0 during data bit 4 of 0xF0 → next edge TX_OUT=1, BUSY=0. A new 0x81 sent afterwards is transmitted complete and correct.
- Macro undefined, P_DATA=0x5A → TX_OUT 0,0,1,0,1,1,0,1,0,1(stop). BUSY high for 10 cycles.
